// File: rtl/div_pkg.sv
// Shared types, constants and the sign helper for the radix-2 divider.
package div_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int DIV_CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negate when en is set, pass-through otherwise.
  // Used both for taking magnitudes on accept and for sign correction.
  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] x,
                                                  input logic                 en);
    return en ? (~x + DIV_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/radix2_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per cycle.
//
// Handshake: a request is accepted on a rising edge where div_valid=1,
// div_ready=1 (IDLE only) and flush=0; operands and div_signed are sampled
// on that edge. out_valid is a one-cycle pulse; quotient/remainder are
// registered and hold their value until the next result is loaded, so the
// requester may read them any time after the pulse.
//
// Timing: the result registers and out_valid are loaded on the edge that
// enters DONE, so out_valid is high for the whole DONE cycle. A normal
// divide spends WIDTH cycles in CALC; divide-by-zero skips CALC entirely.
module radix2_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic             flush,
  output logic             div_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       state_dbg_o
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] res_quo;
  logic [WIDTH-1:0] res_rem;

  assign accept      = div_valid && (state_q == IDLE) && !flush;
  assign dvd_neg     = div_signed & dividend[WIDTH-1];
  assign dvs_neg     = div_signed & divisor[WIDTH-1];
  assign div_ready   = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign state_dbg_o = state_q;

  // One restoring iteration: shift {rem,quo} left, trial-subtract the divisor
  // magnitude and keep the difference when it does not go negative.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    quo_sh = {quo_q[WIDTH-2:0], 1'b0};
    diff   = rem_sh - {1'b0, dvs_q};
    rem_d  = rem_sh[WIDTH-1:0];
    quo_d  = quo_sh;
    if (!diff[WIDTH]) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = quo_sh | WIDTH'(1);
    end
    res_quo = neg_if(quo_d, sign_q_q);
    res_rem = neg_if(rem_d, sign_r_q);
  end

  // Control FSM plus datapath registers; out_valid and results are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q_q <= dvd_neg ^ dvs_neg;
            sign_r_q <= dvd_neg;
            if (divisor == '0) begin
              // Divide by zero: quotient all ones, remainder is the raw dividend.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
            end else begin
              state_q <= CALC;
              cnt_q   <= '0;
              rem_q   <= '0;
              quo_q   <= neg_if(dividend, dvd_neg);
              dvs_q   <= neg_if(divisor, dvs_neg);
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= res_quo;
              remainder_q <= res_rem;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/radix2_divider.md
Name: radix2_divider

Overview:
- Multi-cycle 64-bit integer divider. It is the responder side of the ALU's div_valid/div_ready/out_valid handshake and serves DIV/DIVU/REM/REMU and their W forms.
- The ALU pre-extends W-form operands to 64 bits, so this block is width-agnostic.
- Core algorithm: restoring shift-subtract, one quotient bit per cycle, on operand magnitudes, followed by sign correction.

Parameters:
- WIDTH, 64, operand/result width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dividend  in  WIDTH  dividend, sampled on handshake
- divisor  in  WIDTH  divisor, sampled on handshake
- div_valid  in  1  request valid
- div_signed  in  1  1 = signed division/remainder, sampled on handshake
- flush  in  1  abort current operation
- div_ready  out  1  can accept a request (IDLE only)
- out_valid  out  1  one-cycle result pulse
- quotient  out  WIDTH  quotient; stable from the out_valid cycle until the next accept
- remainder  out  WIDTH  remainder; same stability as quotient

Behaviour:
- States: IDLE, CALC, DONE.
- Reset: state=IDLE, div_ready=1, out_valid=0, quotient=0, remainder=0, counter=0.
- Accept: div_valid && div_ready sampled high at a rising edge, in IDLE, with flush=0.
  - Latch sign_q = div_signed & (dividend[MSB] ^ divisor[MSB]).
  - Latch sign_r = div_signed & dividend[MSB].
  - Latch magnitudes: |x| when div_signed, raw x otherwise.
- Divisor zero at accept: go directly to DONE. quotient = all ones; remainder = original dividend (unsigned and signed alike).
- Divisor nonzero at accept: go to CALC with counter=0, partial remainder=0, working quotient=|dividend|.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract |divisor| from rem (WIDTH+1 bits).
  - If non-negative: take the difference and set quo LSB=1.
  - After WIDTH iterations (counter==WIDTH-1), go to DONE.
- DONE (exactly one cycle):
  - out_valid=1.
  - quotient = sign_q ? -quo : quo.
  - remainder = sign_r ? -rem : rem.
  - Next state is IDLE.
- Latency from accept edge to out_valid high: WIDTH+1 cycles (65) normally; 1 cycle for divide-by-zero.
- Signed overflow (MIN / -1) needs no special case. The result is quotient=MIN, remainder=0, per RISC-V.
- div_ready is 1 only in IDLE. It is 0 in CALC and DONE, so a request held during DONE is accepted the cycle after out_valid.
- Result registers change only when loaded in DONE. They hold while the ALU stalls (old_div path), and later requests do not disturb them until the next DONE.
- flush in CALC or DONE: next state IDLE, out_valid=0 the next cycle, result registers untouched.
- flush in IDLE: any coincident request is not accepted.
- flush and out_valid in the same cycle: the pulse still occurs; next state IDLE.
- rst mid-operation: all state returns to reset values the next cycle; no out_valid.
- div_valid dropping during CALC is ignored; the operation completes.

Decomposition:
- Shared package (div_pkg):
  - State enum {IDLE, CALC, DONE}.
  - Constants: WIDTH default, CNT_W.
  - A negate/abs helper function reused by the sign stages.
- Single module; no sub-module. The iteration datapath is too small to split.

Test Plan:
- Unsigned: dividend=100, divisor=7, div_signed=0 → out_valid exactly 65 cycles after accept; quotient=14, remainder=2; div_ready low throughout CALC/DONE.
- Signed: dividend=-100, divisor=7, div_signed=1 → quotient=-14 (0xFFFF_FFFF_FFFF_FFF2), remainder=-2 (0xFFFF_FFFF_FFFF_FFFE).
- Divide by zero: dividend=0x8000_0000_0000_0005, divisor=0, both signedness values → out_valid 1 cycle after accept; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x8000_0000_0000_0005.
- Overflow: dividend=0x8000_0000_0000_0000, divisor=-1, signed → quotient=0x8000_0000_0000_0000, remainder=0.
- Flush mid-CALC at iteration 30 → no out_valid; div_ready=1 next cycle; prior quotient/remainder unchanged; new request 50/5 then yields quotient=10, remainder=0.
- Back-to-back with div_valid held high: second request accepted the cycle after the first out_valid. Results remain stable across a 10-cycle idle gap after out_valid.
